// File: rtl/test_demo.sv
// test_demo: enable-gated 8-bit up-counter behind an emulated clock-IP lock.
// Optional feature macro: TEST_DEMO_LOCK_EMU_EN
//   defined   -> after reset the block waits LOCK_CYCLES edges (LOCKING) before counting
//   undefined -> lock logic is omitted and reset lands directly in READY
module test_demo #(
  parameter int unsigned LOCK_CYCLES = 8,
  parameter logic [7:0]  STEP        = 8'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] out
);

  typedef enum logic [1:0] {
    StLocking = 2'd0,
    StReady   = 2'd1,
    StRun     = 2'd2
  } state_e;

  // LOCK_CYCLES must fit the 8-bit lock counter and be non-zero.
  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 255) begin : gen_bad_lock_cycles
    $error("LOCK_CYCLES out of range 1..255");
  end

`ifdef TEST_DEMO_LOCK_EMU_EN
  localparam state_e     ResetState = StLocking;
  localparam logic [7:0] LockLast   = 8'(LOCK_CYCLES - 1);
  logic [7:0] lock_cnt_q, lock_cnt_d;
`else
  localparam state_e     ResetState = StReady;
`endif

  state_e     state_q, state_d;
  logic [7:0] out_q, out_d;

  // Next-state, lock counter and counter update; increments land on the enabling edge.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
`ifdef TEST_DEMO_LOCK_EMU_EN
    lock_cnt_d = lock_cnt_q;
`endif
    unique case (state_q)
      StLocking: begin
`ifdef TEST_DEMO_LOCK_EMU_EN
        // Enable is ignored here; the counter freezes once lock is reached.
        if (lock_cnt_q == LockLast) begin
          state_d = StReady;
        end else begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
`else
        state_d = StReady;
`endif
      end
      StReady: begin
        if (enable) begin
          out_d   = out_q + STEP;
          state_d = StRun;
        end
      end
      StRun: begin
        if (enable) begin
          out_d = out_q + STEP;
        end else begin
          state_d = StReady;
        end
      end
      default: state_d = ResetState;
    endcase
  end

  // State registers with synchronous active-high reset overriding enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ResetState;
      out_q   <= 8'd0;
`ifdef TEST_DEMO_LOCK_EMU_EN
      lock_cnt_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
`ifdef TEST_DEMO_LOCK_EMU_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_test_demo.sv
// Scoreboard bench for test_demo: two instances (default and STEP=100/LOCK_CYCLES=3).
module tb_test_demo;

  localparam int unsigned Lock0 = 8;
  localparam int unsigned Lock1 = 3;
  localparam logic [7:0]  Step0 = 8'd1;
  localparam logic [7:0]  Step1 = 8'd100;
`ifdef TEST_DEMO_LOCK_EMU_EN
  localparam int unsigned Edges0 = Lock0;
  localparam int unsigned Edges1 = Lock1;
`else
  localparam int unsigned Edges0 = 0;
  localparam int unsigned Edges1 = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] out0, out1;

  int errors = 0;
  int checks = 0;

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [7:0]  m0 = 8'd0;
  logic [7:0]  m1 = 8'd0;
  int unsigned rel = 0;

  always #5 clk = ~clk;

  test_demo #(.LOCK_CYCLES(Lock0), .STEP(Step0)) u_dut0 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .out    (out0)
  );

  test_demo #(.LOCK_CYCLES(Lock1), .STEP(Step1)) u_dut1 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .out    (out1)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the value out must show after the coming edge.
  task automatic cycle(input logic r, input logic e);
    @(negedge clk);
    reset  = r;
    enable = e;
    if (r) begin
      m0  = 8'd0;
      m1  = 8'd0;
      rel = 0;
    end else begin
      rel++;
      if (e && rel > Edges0) m0 = m0 + Step0;
      if (e && rel > Edges1) m1 = m1 + Step1;
    end
    q0.push_back(m0);
    q1.push_back(m1);
  endtask

  // Hand-computed check of out0 right after the edge of the last driven cycle.
  task automatic hand(input string name, input logic [7:0] exp);
    @(posedge clk);
    #2;
    check(name, out0, exp);
  endtask

  // Monitor: compare every presented output against the scoreboard front.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) check("out0", out0, q0.pop_front());
      if (q1.size() > 0) check("out1", out1, q1.pop_front());
    end
  end

  initial begin
    // Held reset with enable high.
    repeat (5) cycle(1'b1, 1'b1);
    hand("reset_hold", 8'd0);

    // Enable from release: ignored during lock, then 1, 2, 3...
    repeat (12) cycle(1'b0, 1'b1);
    hand("lock_then_count", 8'(12 - Edges0));

    // Enable raised 15 cycles after release, held 200, then 60 more to wrap.
    cycle(1'b1, 1'b0);
    repeat (15) cycle(1'b0, 1'b0);
    repeat (200) cycle(1'b0, 1'b1);
    hand("count_200", 8'd200);
    repeat (60) cycle(1'b0, 1'b1);
    hand("wrap_260", 8'd4);

    // Hold with enable low, then resume.
    cycle(1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b1);
    hand("at_10", 8'd10);
    repeat (5) cycle(1'b0, 1'b0);
    hand("hold_10", 8'd10);
    cycle(1'b0, 1'b1);
    hand("resume_11", 8'd11);

    // Reset pulse mid-count restarts the lock sequence.
    repeat (39) cycle(1'b0, 1'b1);
    hand("at_50", 8'd50);
    cycle(1'b1, 1'b1);
    hand("reset_pulse", 8'd0);
    cycle(1'b0, 1'b1);
    hand("first_after_pulse", (Edges0 == 0) ? 8'd1 : 8'd0);
    repeat (Edges0) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    hand("resume_after_lock", 8'd2);

    // Scoreboard must be drained within a bounded number of cycles.
    for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/test_demo.md
TEST_DEMO -- requirements
Module: test_demo

Interface
REQ-001 Parameter LOCK_CYCLES, default 8, number of clock cycles after reset release before the emulated clock-IP lock asserts (range 1..255).
REQ-002 Parameter STEP, default 1, 8-bit increment added to out per enabled cycle.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  count enable, level-sensitive, sampled on rising clk.
REQ-006 out  output  8  registered counter value.

Function
REQ-007 Internal FSM SHALL have states LOCKING, READY, RUN.
REQ-008 LOCKING: 8-bit lock counter increments each cycle; transitions to READY on the edge where the counter reaches LOCK_CYCLES-1, so lock asserts exactly LOCK_CYCLES edges after the first edge with reset low.
REQ-009 READY: out holds; transition to RUN on an edge where enable=1, and out SHALL increment by STEP on that same edge.
REQ-010 RUN: on each edge with enable=1, out <= (out + STEP) mod 256; on an edge with enable=0, out holds and the state returns to READY.
REQ-011 Latency: enable sampled high at edge N (state READY or RUN) -> updated out visible after edge N; no pipeline delay.
REQ-012 Enable asserted during LOCKING SHALL be ignored: no increment, no queued counts.
REQ-013 Wrap-around: 255 + 1 -> 0 with no flag or saturation; STEP>1 wraps modulo 256.
REQ-014 out SHALL be driven directly from a flip-flop, with no combinational path from enable.
REQ-015 Lock counter SHALL stop once READY is reached; lock never deasserts except via reset.

Reset
REQ-016 reset=1 at a rising edge SHALL set out=0, lock counter=0, state=LOCKING, overriding enable.
REQ-017 Reset mid-operation SHALL discard the count and restart the full lock sequence.
REQ-018 Held reset keeps all state at reset values; no state change until the first edge with reset=0.

Configuration
REQ-019 Macro TEST_DEMO_LOCK_EMU_EN defined: LOCKING state and lock counter present as in REQ-008.
REQ-020 Macro undefined: lock logic omitted; reset goes directly to READY, so enable at the first edge after reset release increments out; LOCK_CYCLES is unused.

Verification
REQ-021 Reset held 5 cycles with enable=1 -> out=0 throughout.
REQ-022 Macro defined, enable=1 from reset release -> out=0 for the first 8 edges, then 1,2,3... on successive edges.
REQ-023 Enable raised 15 cycles after release, held 200 cycles -> out=200 (0xC8).
REQ-024 Enabled for 260 cycles after lock -> out passes 255->0 and ends at 4.
REQ-025 Enable low for 5 cycles at out=10 -> out holds 10, then reads 11 after the next enabled edge.
REQ-026 Reset pulsed 1 cycle at out=50 -> out=0 after that edge; increments resume only after a further 8 cycles (macro defined) or immediately (macro undefined).
